// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter.
// Prepends a 1..DATA_BYTE_WD byte header, taken from a separate header
// channel, to every payload packet. The result is re-packed onto the same bus
// width, big-endian (the top byte lane goes on the wire first).
//
// Ports
//   clk, rst_n        clock; synchronous reset, asserted high (legacy name)
//   valid_in/data_in/keep_in/last_in/ready_in
//                     payload channel; keep_in is MSB-contiguous on the last beat
//   valid_out/data_out/keep_out/last_out/ready_out
//                     packed output stream; bytes with keep_out=0 read as zero
//   valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert
//                     header channel; header bytes are LSB-aligned in data_insert
//
// state | meaning
// IDLE  | waiting for the next header; payload blocked
// DATA  | header held as residual; payload beats merged with the residual
// FLUSH | last payload beat overflowed; residual tail still to be emitted
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
    output logic                    ready_insert
);
    localparam int CW = BYTE_CNT_WD + 2;

    typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_e;

    state_e                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;
    // Residual bytes are kept LSB-aligned so that one right shift of
    // {residual, payload} by H bytes yields the next packed beat.
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [BYTE_CNT_WD:0]    hdr_cnt_q, hdr_cnt_d;
    logic [CW-1:0]           rem_cnt_q, rem_cnt_d;

    logic                    out_free;
    logic [DATA_WD-1:0]      pay_m;
    logic [CW-1:0]           tot_cnt;

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] en);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{en[i]}};
        return m;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] en);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) n = n + CW'(en[i]);
        return n;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CW-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) if (i < int'(cnt)) k[DATA_BYTE_WD-1-i] = 1'b1;
        return k;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] low_keep(input logic [BYTE_CNT_WD:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) if (i < int'(cnt)) k[i] = 1'b1;
        return k;
    endfunction

    assign out_free = ~valid_q | ready_out;
    // Unused lanes of the last beat are zeroed up front so they never leak
    // into the packed output or into the flushed tail.
    assign pay_m    = data_in & byte_mask(keep_in);
    assign tot_cnt  = CW'(hdr_cnt_q) + popcnt(keep_in);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;
        res_d        = res_q;
        hdr_cnt_d    = hdr_cnt_q;
        rem_cnt_d    = rem_cnt_q;
        ready_in     = 1'b0;
        ready_insert = 1'b0;

        if (valid_q && ready_out) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                ready_insert = 1'b1;
                if (valid_insert) begin
                    res_d     = data_insert & byte_mask(keep_insert);
                    hdr_cnt_d = byte_insert_cnt;
                    state_d   = DATA;
                end
            end
            DATA: begin
                ready_in = out_free;
                if (valid_in && out_free) begin
                    valid_d = 1'b1;
                    data_d  = DATA_WD'({res_q, pay_m} >> (8 * int'(hdr_cnt_q)));
                    keep_d  = '1;
                    last_d  = 1'b0;
                    res_d   = pay_m & byte_mask(low_keep(hdr_cnt_q));
                    if (last_in) begin
                        if (tot_cnt <= CW'(DATA_BYTE_WD)) begin
                            keep_d  = top_keep(tot_cnt);
                            last_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // The low H bytes of the masked beat hold the tail
                            // (top-aligned within those H bytes).
                            rem_cnt_d = tot_cnt - CW'(DATA_BYTE_WD);
                            state_d   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = res_q << (8 * (DATA_BYTE_WD - int'(hdr_cnt_q)));
                    keep_d  = top_keep(rem_cnt_q);
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            res_q     <= '0;
            hdr_cnt_q <= '0;
            rem_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            res_q     <= res_d;
            hdr_cnt_q <= hdr_cnt_d;
            rem_cnt_q <= rem_cnt_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
module tb_axi_stream_insert_header;
    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [2:0]  byte_insert_cnt;
    logic        ready_insert;

    axi_stream_insert_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          tot_q[$];
    byte unsigned pay_q[$];
    byte unsigned saved_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int stall_from = 0;
    int stall_to   = 0;

    exp_t        mon_e;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    int          byte_acc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ready_out is low inside the [stall_from, stall_to) cycle window
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            ready_out = !(cyc >= stall_from && cyc < stall_to);
        end
    end

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (rst_n) begin
            prev_stall = 0;
            byte_acc   = 0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(valid_out), 32'd1);
                check_eq("hold_data", data_out, prev_data);
                check_eq("hold_keep", 32'(keep_out), 32'(prev_keep));
                check_eq("hold_last", 32'(last_out), 32'(prev_last));
            end
            if (valid_out && !ready_out) check_eq("rdy_in_stall", 32'(ready_in), 32'd0);
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected", data_out, 32'hxxxxxxxx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_data", data_out, mon_e.data);
                    check_eq("out_keep", 32'(keep_out), 32'(mon_e.keep));
                    check_eq("out_last", 32'(last_out), 32'(mon_e.last));
                end
                byte_acc += $countones(keep_out);
                if (last_out) begin
                    if (tot_q.size() == 0) check_eq("pkt_unexpected", 32'(byte_acc), 32'hxxxxxxxx);
                    else check_eq("pkt_bytes", 32'(byte_acc), 32'(tot_q.pop_front()));
                    byte_acc = 0;
                end
            end
            prev_stall = valid_out && !ready_out;
            prev_data  = data_out;
            prev_keep  = keep_out;
            prev_last  = last_out;
        end
    end

    // which: 0 = header channel, 1 = payload channel
    task automatic wait_hs(input int which);
        bit hs;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            hs = (which != 0) ? ready_in : ready_insert;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 200) begin
                check_eq(which != 0 ? "tmo_ready_in" : "tmo_ready_insert", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic make_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic send_packet(input int h, input logic [31:0] hdr, input int gap_beat,
                               input int stall_beat, input int stall_len, input bit abort);
        byte unsigned s[$];
        exp_t e;
        int nb, nbeats, t_last;
        nb     = pay_q.size();
        nbeats = (nb + 3) / 4;
        t_last = h + nb - 4 * (nbeats - 1);
        for (int i = h - 1; i >= 0; i--) s.push_back(hdr[8*i +: 8]);
        foreach (pay_q[i]) s.push_back(pay_q[i]);
        for (int b = 0; b < s.size(); b += 4) begin
            e.data = '0;
            e.keep = '0;
            for (int k = 0; k < 4; k++) begin
                if (b + k < s.size()) begin
                    e.data[31-8*k -: 8] = s[b+k];
                    e.keep[3-k] = 1'b1;
                end
            end
            e.last = (b + 4 >= s.size());
            if (!abort || b == 0) exp_q.push_back(e);
        end
        if (!abort) tot_q.push_back(s.size());

        @(posedge clk);
        #1;
        valid_insert    = 1'b1;
        data_insert     = hdr;
        keep_insert     = 4'((1 << h) - 1);
        byte_insert_cnt = 3'(h);
        wait_hs(0);
        valid_insert = 1'b0;
        data_insert  = $urandom;

        for (int bt = 0; bt < nbeats; bt++) begin
            if (bt == gap_beat) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            if (bt == stall_beat) begin
                stall_from = cyc + 1;
                stall_to   = cyc + 1 + stall_len;
            end
            for (int k = 0; k < 4; k++) begin
                if (bt * 4 + k < nb) begin
                    data_in[31-8*k -: 8] = pay_q[bt*4+k];
                    keep_in[3-k] = 1'b1;
                end else begin
                    data_in[31-8*k -: 8] = 8'h5A;
                    keep_in[3-k] = 1'b0;
                end
            end
            last_in  = (bt == nbeats - 1);
            valid_in = 1'b1;
            wait_hs(1);
            valid_in = 1'b0;
            last_in  = 1'b0;
            if (abort) begin
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                check_eq("rst_valid_out", 32'(valid_out), 32'd0);
                check_eq("rst_ready_insert", 32'(ready_insert), 32'd1);
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        check_eq("post_last_ready_insert", 32'(ready_insert), 32'(t_last <= 4));
    endtask

    initial begin
        rst_n = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_data", data_out, 32'd0);
        check_eq("rst_keep", 32'(keep_out), 32'd0);
        check_eq("rst_last", 32'(last_out), 32'd0);
        check_eq("rst_ready_insert", 32'(ready_insert), 32'd1);
        check_eq("rst_ready_in", 32'(ready_in), 32'd0);

        // H=3, two payload beats, tail flushed
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_packet(3, 32'hAABBCCDD, -1, -1, 0, 1'b0);

        // H=4: header goes out alone
        pay_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
        send_packet(4, 32'h01020304, -1, -1, 0, 1'b0);

        // H=1, single-beat packet that fits exactly
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_packet(1, 32'h000000EE, -1, -1, 0, 1'b0);

        // 8-beat packet with an 8-cycle downstream stall mid-packet
        make_payload(28 + $urandom_range(1, 4));
        send_packet($urandom_range(1, 4), $urandom, -1, 3, 8, 1'b0);

        // Same packet unstalled, then with an input gap and a stall
        begin
            int h5;
            logic [31:0] hd5;
            h5  = $urandom_range(1, 4);
            hd5 = $urandom;
            make_payload(13);
            saved_q = pay_q;
            send_packet(h5, hd5, -1, -1, 0, 1'b0);
            pay_q = saved_q;
            send_packet(h5, hd5, 2, 2, 3, 1'b0);
        end

        // Reset during DATA, then a normal packet
        make_payload(10);
        send_packet(2, $urandom, -1, -1, 0, 1'b1);
        make_payload(7);
        send_packet(3, $urandom, -1, -1, 0, 1'b0);

        // Sweep of header sizes against short packets
        for (int h = 1; h <= 4; h++) begin
            for (int n = 1; n <= 6; n++) begin
                make_payload(n);
                send_packet(h, $urandom, -1, (n == 5) ? 0 : -1, 2, 1'b0);
            end
        end

        for (int i = 0; i < 200 && (exp_q.size() != 0 || tot_q.size() != 0); i++) @(posedge clk);
        check_eq("drain_beats", 32'(exp_q.size()), 32'd0);
        check_eq("drain_pkts", 32'(tot_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
